// File: rtl/ibex_rf_writeback.sv
// rtl/ibex_rf_writeback.sv - register-file writeback stage merging ALU results and load responses
module ibex_rf_writeback #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 ex_valid_i,
    input  logic                 ex_we_i,
    input  logic [4:0]           ex_rd_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,

    input  logic                 lsu_issue_i,
    input  logic [4:0]           lsu_rd_i,
    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,

    output logic                 load_pending_o,
    output logic [4:0]           load_rd_o,

    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 err_o
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e               state_q;
    logic                 hold_valid_q;
    logic [4:0]           hold_rd_q;
    logic [DataWidth-1:0] hold_wdata_q;

    logic                 load_resp;
    logic                 waw;
    logic                 ex_accept;
    logic                 ex_write;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic [DataWidth-1:0] wr_data;
    logic                 hold_set;
    logic                 hold_clr;
    logic                 err_d;

    // x0 is hardwired to zero; in the embedded profile x16-x31 do not exist.
    function automatic logic rd_writable(input logic [4:0] rd);
        return (rd != 5'd0) && !(RV32E && rd[4]);
    endfunction

    // Hazard detection and execute handshake.
    always_comb begin
        load_resp  = lsu_rvalid_i & (state_q == ST_WAIT);
        waw        = load_pending_o & ex_valid_i & ex_we_i &
                     (ex_rd_i == load_rd_o) & (ex_rd_i != 5'd0);
        ex_ready_o = !hold_valid_q & !waw;
        ex_accept  = ex_valid_i & ex_ready_o;
        // Results that would be suppressed anyway never occupy the holding register.
        ex_write   = ex_accept & ex_we_i & rd_writable(ex_rd_i);
    end

    // Write-port arbitration: load response, then held result, then fresh ALU result.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = rf_waddr_o;
        wr_data  = rf_wdata_o;
        hold_set = 1'b0;
        hold_clr = 1'b0;
        if (load_resp) begin
            if (!lsu_err_i && rd_writable(load_rd_o)) begin
                wr_en   = 1'b1;
                wr_addr = load_rd_o;
                wr_data = lsu_rdata_i;
            end
            hold_set = ex_write;
        end else if (hold_valid_q) begin
            wr_en    = 1'b1;
            wr_addr  = hold_rd_q;
            wr_data  = hold_wdata_q;
            hold_clr = 1'b1;
        end else if (ex_write) begin
            wr_en   = 1'b1;
            wr_addr = ex_rd_i;
            wr_data = ex_wdata_i;
        end
    end

    // Error sources: bus error on a real response, spurious response, overlapping issue.
    always_comb begin
        err_d = (lsu_rvalid_i & (state_q == ST_IDLE)) |
                (load_resp & lsu_err_i) |
                (lsu_issue_i & (state_q == ST_WAIT) & !lsu_rvalid_i);
    end

    // Registered write port; address and data keep their last value when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= 5'd0;
            rf_wdata_o <= '0;
            err_o      <= 1'b0;
        end else begin
            rf_we_o <= wr_en;
            err_o   <= err_d;
            if (wr_en) begin
                rf_waddr_o <= wr_addr;
                rf_wdata_o <= wr_data;
            end
        end
    end

    // One-entry holding register for ALU results that lost the write port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_rd_q    <= 5'd0;
            hold_wdata_q <= '0;
        end else if (hold_set) begin
            hold_valid_q <= 1'b1;
            hold_rd_q    <= ex_rd_i;
            hold_wdata_q <= ex_wdata_i;
        end else if (hold_clr) begin
            hold_valid_q <= 1'b0;
        end
    end

    // Outstanding-load tracker; a response with a same-cycle issue re-arms for the new load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            load_pending_o <= 1'b0;
            load_rd_o      <= 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lsu_issue_i) begin
                        state_q        <= ST_WAIT;
                        load_pending_o <= 1'b1;
                        load_rd_o      <= lsu_rd_i;
                    end
                end
                ST_WAIT: begin
                    if (lsu_rvalid_i) begin
                        if (lsu_issue_i) begin
                            load_rd_o <= lsu_rd_i;
                        end else begin
                            state_q        <= ST_IDLE;
                            load_pending_o <= 1'b0;
                            load_rd_o      <= 5'd0;
                        end
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    load_pending_o <= 1'b0;
                    load_rd_o      <= 5'd0;
                end
            endcase
        end
    end

endmodule
